// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl shared definitions.
// Register offsets, FSM states, strobe helper.
package irq_ctrl_pkg;

  localparam int DATA_BUS = 64;
  localparam logic [31:0] REG_ZERO = 32'h0;

  localparam logic [DATA_BUS-1:0] IRQ_ENABLE_OFF  = 64'h00;
  localparam logic [DATA_BUS-1:0] IRQ_PENDING_OFF = 64'h04;
  localparam logic [DATA_BUS-1:0] IRQ_CTRL_OFF    = 64'h08;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  function automatic logic [31:0] strb_mask(
    input logic [3:0] s
  );
    return {{8{s[3]}}, {8{s[2]}},
            {8{s[1]}}, {8{s[0]}}};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder.
// Purely combinational.
module irq_prio_enc #(
  parameter int N    = 8,
  parameter int ID_W = 5
) (
  input  logic [N-1:0]    vec,
  output logic            valid,
  output logic [ID_W-1:0] idx
);

  // scan downward so the lowest set bit is written last
  always_comb begin
    valid = |vec;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: enable/pending/ctrl regs,
// priority select, req/ack/done handshake.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 5
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [63:0]         WriteAddr,
  input  logic [63:0]         WriteData,
  input  logic                WriteEnable,
  input  logic [3:0]          WriteStrb,
  output logic                SlaverWriteReady,
  input  logic [NUM_SRC-1:0]  IrqSrc,
  output logic                IrqReq,
  output logic [ID_W-1:0]     IrqId,
  input  logic                IrqAck,
  input  logic                IrqDone,
  output logic                IrqBusy
);

  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] pending_d;
  logic [NUM_SRC-1:0] claim;
  logic [NUM_SRC-1:0] cand;
  logic               ctrl_q;
  logic               wready_q;
  irq_state_e         state_q;
  irq_state_e         state_d;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    id_d;
  logic [ID_W-1:0]    win_id;
  logic               win_vld;
  logic [31:0]        wdata;
  logic [31:0]        wmask;
  logic [31:0]        en_wr;
  logic [31:0]        w1c;
  logic               hit_en;
  logic               hit_pnd;
  logic               hit_ctl;
  logic               unused;

  assign wdata = WriteData[31:0];
  assign wmask = strb_mask(WriteStrb);

  assign hit_en  = WriteEnable &&
                   (WriteAddr == IRQ_ENABLE_OFF);
  assign hit_pnd = WriteEnable &&
                   (WriteAddr == IRQ_PENDING_OFF);
  assign hit_ctl = WriteEnable &&
                   (WriteAddr == IRQ_CTRL_OFF);

  assign en_wr = (32'(enable_q) & ~wmask) |
                 (wdata & wmask);
  assign w1c   = hit_pnd ? (wdata & wmask)
                         : REG_ZERO;

  assign claim = (state_q == REQ && IrqAck)
               ? (NUM_SRC'(1) << id_q) : '0;

  // a source high this cycle beats any clear
  assign pending_d =
    (pending_q & ~(w1c[NUM_SRC-1:0] | claim)) |
    IrqSrc;

  assign cand = pending_q & enable_q &
                {NUM_SRC{ctrl_q}};

  assign unused = ^{WriteData[63:32], en_wr, w1c};

  irq_prio_enc #(
    .N    (NUM_SRC),
    .ID_W (ID_W)
  ) u_prio (
    .vec   (cand),
    .valid (win_vld),
    .idx   (win_id)
  );

  // register file, pending latch, write ready
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      enable_q  <= '0;
      pending_q <= '0;
      ctrl_q    <= 1'b0;
      wready_q  <= 1'b0;
    end else begin
      wready_q  <= hit_en | hit_pnd | hit_ctl;
      pending_q <= pending_d;
      if (hit_en)
        enable_q <= en_wr[NUM_SRC-1:0];
      if (hit_ctl && WriteStrb[0])
        ctrl_q <= wdata[0];
    end
  end

  // handshake state and captured id
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  // next state; REQ never withdraws, ack beats done
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = REQ;
          id_d    = win_id;
        end
      end
      REQ: begin
        if (IrqAck) state_d = SERVICE;
      end
      SERVICE: begin
        if (IrqDone) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign SlaverWriteReady = wready_q;
  assign IrqReq  = (state_q == REQ);
  assign IrqBusy = (state_q != IDLE);
  assign IrqId   = id_q;

endmodule
